// File: rtl/mandel_pixel_scheduler_pkg.sv
// Shared types and constants for the Mandelbrot pixel scheduler.
// Coordinates are signed 4.23 fixed point. Iteration counts are 11 bits wide.
package mandel_pixel_scheduler_pkg;

  localparam int FRAC_BITS = 23;
  localparam int COORD_W   = 27;
  localparam int CNT_W     = 11;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic        [CNT_W-1:0]   count_t;

  // RGB 3-3-2 palette, ordered from deepest (in set) to fastest escape
  localparam logic [7:0] COLOR_IN_SET = 8'h00;
  localparam logic [7:0] COLOR_GE64   = 8'hE0;
  localparam logic [7:0] COLOR_GE16   = 8'hFC;
  localparam logic [7:0] COLOR_GE8    = 8'h1C;
  localparam logic [7:0] COLOR_GE4    = 8'h1F;
  localparam logic [7:0] COLOR_GE2    = 8'h03;
  localparam logic [7:0] COLOR_LOW    = 8'h01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_WRITE
  } state_t;

endpackage

// File: rtl/mandel_pixel_scheduler_color_map.sv
// Combinational escape-count to RGB 3-3-2 colour lookup.
// The scheduler registers the result.
module mandel_color_map
  import mandel_pixel_scheduler_pkg::*;
#(
  parameter count_t MAX_ITER = 11'd100
) (
  input  count_t      count,
  output logic [7:0]  color
);

  always_comb begin
    color = COLOR_LOW;
    if (count >= MAX_ITER)            color = COLOR_IN_SET;
    else if (count >= count_t'(64))   color = COLOR_GE64;
    else if (count >= count_t'(16))   color = COLOR_GE16;
    else if (count >= count_t'(8))    color = COLOR_GE8;
    else if (count >= count_t'(4))    color = COLOR_GE4;
    else if (count >= count_t'(2))    color = COLOR_GE2;
  end

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Raster-order pixel scheduler: steps (cr, ci) across the frame, runs the
// iterator once per pixel and writes the resulting colour to the frame buffer.
module mandel_pixel_scheduler
  import mandel_pixel_scheduler_pkg::*;
#(
  parameter int     H_RES    = 640,
  parameter int     V_RES    = 480,
  parameter int     ADDR_W   = 19,
  parameter count_t MAX_ITER = 11'd100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  coord_t            x_start,
  input  coord_t            y_start,
  input  coord_t            dx,
  input  coord_t            dy,
  output coord_t            cr,
  output coord_t            ci,
  output logic              iter_reset,
  input  count_t            iter_counter,
  input  logic              iter_done,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_color,
  output logic              pix_we,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  coord_t           x_start_q;
  coord_t           dx_q;
  coord_t           dy_q;
  logic [7:0]       map_color;
  logic             col_last;
  logic             row_last;

  mandel_color_map #(
    .MAX_ITER (MAX_ITER)
  ) u_color_map (
    .count (iter_counter),
    .color (map_color)
  );

  assign col_last = (col == COL_W'(H_RES - 1));
  assign row_last = (row == ROW_W'(V_RES - 1));

  // cr/ci move only on a start or a completed write, so the iterator sees
  // constant coordinates for the whole LOAD/WAIT span of a pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      x_start_q  <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      cr         <= '0;
      ci         <= '0;
      iter_reset <= 1'b1;
      pix_addr   <= '0;
      pix_color  <= '0;
      pix_we     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          iter_reset <= 1'b1;
          if (start) begin
            x_start_q <= x_start;
            dx_q      <= dx;
            dy_q      <= dy;
            cr        <= x_start;
            ci        <= y_start;
            col       <= '0;
            row       <= '0;
            pix_addr  <= '0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          iter_reset <= 1'b0;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          if (iter_done) begin
            pix_color <= map_color;
            pix_we    <= 1'b1;
            state     <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (pix_ready) begin
            pix_we     <= 1'b0;
            pix_addr   <= pix_addr + ADDR_W'(1);
            iter_reset <= 1'b1;
            if (col_last && row_last) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else if (col_last) begin
              col   <= '0;
              row   <= row + ROW_W'(1);
              cr    <= x_start_q;
              ci    <= ci - dy_q;
              state <= S_LOAD;
            end else begin
              col   <= col + COL_W'(1);
              cr    <= cr + dx_q;
              state <= S_LOAD;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mandel_pixel_scheduler.md
# mandel_pixel_scheduler

Upstream control stage for the Mandelbrot escape-time iterator. The block walks every pixel of an H_RES×V_RES frame in raster order and derives each pixel's complex coordinate (cr, ci) in 4.23 fixed point. For each pixel it restarts the iterator, waits for its done flag, maps the returned iteration count to an 8-bit colour, and writes that colour to the VGA frame buffer through a ready/valid write port.

## Interface
- H_RES, 640, pixels per row
- V_RES, 480, rows per frame
- ADDR_W, 19, frame-buffer address width (must hold H_RES*V_RES-1)
- MAX_ITER, 11'd100, iteration count treated as "in set"; must match iterator limit
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock domain
- start  in  1  one-cycle pulse, begin a frame; ignored while busy
- x_start  in  27  signed 4.23, cr of column 0
- y_start  in  27  signed 4.23, ci of row 0 (top)
- dx  in  27  signed 4.23, cr step per column
- dy  in  27  signed 4.23, ci decrement per row
- cr, ci  out  27  signed 4.23, to iterator
- iter_reset  out  1  to iterator reset
- iter_counter  in  11  from iterator counter
- iter_done  in  1  from iterator done
- pix_addr  out  ADDR_W  row*H_RES+col
- pix_color  out  8  RGB 3-3-2
- pix_we  out  1  write valid
- pix_ready  in  1  frame buffer accepts write
- busy  out  1  high from accepted start to frame end
- frame_done  out  1  one-cycle pulse after last write

## Operation
- States: IDLE, LOAD, WAIT, WRITE.
- IDLE: when start=1, latch x_start, y_start, dx, dy; set col=0, row=0, addr=0, cr=x_start, ci=y_start; go to LOAD.
- LOAD: one cycle, iter_reset=1; go to WAIT.
- WAIT: iter_reset=0; on the first cycle iter_done=1, register pix_color=colour(iter_counter); go to WRITE.
- WRITE: pix_we=1, pix_addr/pix_color held stable until pix_we&&pix_ready, which completes the transfer. On transfer:
  - if last pixel (col=H_RES-1, row=V_RES-1): pulse frame_done, go to IDLE;
  - elif col=H_RES-1: col=0, row+=1, cr=x_start, ci-=dy, go to LOAD;
  - else: col+=1, cr+=dx, go to LOAD.
  - addr increments by 1 on every transfer; no multiplier is used.
- cr/ci change only on a WRITE transfer or a start. They stay constant throughout LOAD and WAIT because the iterator samples them every cycle.
- Arithmetic: 27-bit two's complement add/sub that wraps silently with no saturation; the caller keeps the window in range.
- Colour map (sub-module):
  - count≥MAX_ITER → 8'h00
  - ≥64 → 8'hE0
  - ≥16 → 8'hFC
  - ≥8 → 8'h1C
  - ≥4 → 8'h1F
  - ≥2 → 8'h03
  - else 8'h01
- start while busy: ignored; latched operands are unchanged.
- Reset at any point, including mid-frame or mid-write: go to IDLE and abandon the frame; no frame_done is produced.

## Timing
- Reset values: state IDLE, cr=0, ci=0, iter_reset=1, pix_addr=0, pix_color=0, pix_we=0, busy=0, frame_done=0. iter_reset is held high in IDLE, so the iterator stays cleared.
- busy rises the cycle after start is accepted and falls with frame_done.
- iter_done is ignored during LOAD. Stale done from the previous pixel is cleared by the iterator on the LOAD edge.
- Per-pixel cost: 1 (LOAD) + N (WAIT, N≥1) + 1+stall (WRITE).
  - For the interior point c=0 with MAX_ITER=100, iter_done is first seen on the 101st WAIT cycle.
- frame_done is asserted in the cycle after the final transfer.

## Structure
- Shared package: FRAC_BITS=23, COORD_W=27, CNT_W=11, colour constants, state encoding.
- Sub-module mandel_color_map: combinational count→colour. The scheduler registers its output.
- The iterator is instantiated by the parent, not inside this block.

## Test plan
- Params H_RES=4, V_RES=3, with an iterator model that returns done after 3 cycles with count 5. Drive start with x_start=27'h7000000 (-2.0), dx=27'h0400000 (0.5), y_start=27'h0800000 (1.0), dy=27'h0400000.
  - Expect 12 writes at addr 0..11, all colour 8'h1F.
  - Expect cr sequence -2,-1.5,-1,-0.5 per row; ci values 1.0, 0.5, 0.
  - Expect exactly one frame_done.
- Real iterator, single pixel cr=ci=0 → WAIT lasts 101 cycles, colour 8'h00.
- Real iterator, cr=27'h1000000 (2.0), ci=0 → escapes with count 1, colour 8'h01.
- Hold pix_ready=0 for 7 cycles in WRITE → addr/colour/cr stable, no LOAD, no lost or duplicated write.
- Pulse start mid-frame → ignored, addresses continue in sequence; assert reset mid-frame → next cycle IDLE, outputs at reset values, new start restarts at addr 0.
- Window with dx=27'h3FFFFFF crossing +8.0 → cr wraps to negative with no error or stall.
